// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the RAM.
// The slave modport is the arbiter; master is the core plus RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              ram_REN;
    logic              ram_WEN;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ready;
    logic              ram_error;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ram_load, ram_ready,
        output ihit, iload, dhit, dload,
        output ram_REN, ram_WEN, ram_addr, ram_store,
        output ram_error
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ram_load, ram_ready,
        input  ihit, iload, dhit, dload,
        input  ram_REN, ram_WEN, ram_addr, ram_store,
        input  ram_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data first, fetch guaranteed by a streak
// limit, with a sticky watchdog for a RAM that never answers.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        IACCESS,
        DACCESS,
        ERROR
    } state_t;

    state_t        state;
    logic [SW-1:0] dstreak;
    logic [WW-1:0] wcnt;
    logic          dreq;
    logic          dgrant;
    logic          igrant;
    logic          done;
    logic          tmo;

    assign dreq   = bus.dREN | bus.dWEN;
    assign dgrant = dreq &&
                    (dstreak < SW'(MAX_DSTREAK) || !bus.iREN);
    assign igrant = !dgrant && bus.iREN;

    // A flushed fetch ends the access just like a completion.
    assign done = bus.ram_ready ||
                  (state == IACCESS && !bus.iREN);
    assign tmo  = wcnt == WW'(TIMEOUT - 1);

    assign bus.ihit  = state == IACCESS && bus.ram_ready;
    assign bus.dhit  = state == DACCESS && bus.ram_ready;
    assign bus.iload = bus.ihit ? bus.ram_load : '0;
    assign bus.dload = (bus.dhit && !bus.ram_WEN) ?
                       bus.ram_load : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            dstreak       <= '0;
            wcnt          <= '0;
            bus.ram_error <= 1'b0;
            bus.ram_REN   <= 1'b0;
            bus.ram_WEN   <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_store <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wcnt <= '0;
                    unique case (1'b1)
                        dgrant: begin
                            state         <= DACCESS;
                            bus.ram_addr  <= bus.daddr;
                            bus.ram_store <= bus.dstore;
                            bus.ram_WEN   <= bus.dWEN;
                            bus.ram_REN   <= !bus.dWEN;
                            // dgrant with iREN implies room left
                            dstreak <= bus.iREN ?
                                       dstreak + SW'(1) : '0;
                        end
                        igrant: begin
                            state         <= IACCESS;
                            bus.ram_addr  <= bus.iaddr;
                            bus.ram_store <= '0;
                            bus.ram_REN   <= 1'b1;
                            bus.ram_WEN   <= 1'b0;
                            dstreak       <= '0;
                        end
                        default: ;
                    endcase
                end
                IACCESS, DACCESS: begin
                    if (done || tmo) begin
                        state         <= done ? IDLE : ERROR;
                        bus.ram_error <= !done;
                        bus.ram_REN   <= 1'b0;
                        bus.ram_WEN   <= 1'b0;
                        bus.ram_addr  <= '0;
                        bus.ram_store <= '0;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                ERROR: state <= ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a RAM model,
// per-requester expectation queues and a grant-order reference.
module tb_mem_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32),
        .MAX_DSTREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } itx_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } dtx_t;

    itx_t        iq[$];
    dtx_t        dq[$];
    logic [31:0] ref_mem [0:127];
    logic [31:0] ram [0:127];
    int          checks = 0;
    int          errors = 0;
    int          lat_cfg = 2;
    bit          mon_en = 0;
    int          n_ihit = 0;
    int          n_dhit = 0;

    function automatic logic [31:0] ifn(input logic [31:0] a);
        if (a == 32'h40) return 32'h2002000A;
        return {16'h1234, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // RAM: a fixed or random number of wait cycles per access
    int   cnt = 0;
    bit   busy = 0;
    bit   wr_pend = 0;
    logic [31:0] wa, wd;

    initial begin
        bus.ram_ready = 1'b0;
        bus.ram_load  = '0;
        forever begin
            tick();
            if (wr_pend) begin
                ram[wa[8:2]] = wd;
                wr_pend = 0;
            end
            if (!(bus.ram_REN | bus.ram_WEN)) begin
                busy = 0;
                bus.ram_ready = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    cnt = lat_cfg < 0 ? int'($urandom_range(0, 3))
                                      : lat_cfg;
                end
                bus.ram_ready = cnt == 0;
                if (cnt != 0) cnt--;
            end
            bus.ram_load = bus.ram_ready ? ram[bus.ram_addr[8:2]]
                                         : $urandom;
        end
    end

    always @(negedge CLK) begin
        if (bus.ram_WEN && bus.ram_ready) begin
            wr_pend = 1;
            wa = bus.ram_addr;
            wd = bus.ram_store;
        end
    end

    // Monitor: grant order, access stability, hit data
    int have_pred = 0;
    int pred = 0;
    int cur_src = 0;
    bit prev_hit = 0;
    int streak = 0;

    always @(negedge CLK) begin
        logic act;
        logic ireq;
        logic dreq;
        act = bus.ram_REN | bus.ram_WEN;
        if (!nRST) streak = 0;
        if (!mon_en) begin
            have_pred = 0;
            prev_hit  = 0;
            cur_src   = 0;
        end else begin
            if (prev_hit) chk("idle_gap", 32'(act), 0);
            if (have_pred != 0) begin
                have_pred = 0;
                cur_src = pred;
                if (pred == 2) begin
                    if (dq.size() == 0) chk("dq_nonempty", 0, 1);
                    else begin
                        chk("dgrant_dir",
                            {30'b0, bus.ram_WEN, bus.ram_REN},
                            dq[0].wr ? 2 : 1);
                        chk("dgrant_addr", bus.ram_addr, dq[0].addr);
                        if (dq[0].wr)
                            chk("dgrant_store", bus.ram_store,
                                dq[0].data);
                    end
                end else if (pred == 1) begin
                    chk("igrant_dir",
                        {30'b0, bus.ram_WEN, bus.ram_REN}, 1);
                    if (iq.size() == 0) chk("iq_nonempty", 0, 1);
                    else chk("igrant_addr", bus.ram_addr, iq[0].addr);
                end else begin
                    chk("no_grant", 32'(act), 0);
                end
            end else if (act) begin
                if (cur_src == 2 && dq.size() != 0)
                    chk("dhold_addr", bus.ram_addr, dq[0].addr);
                if (cur_src == 1 && iq.size() != 0)
                    chk("ihold_addr", bus.ram_addr, iq[0].addr);
            end
            prev_hit = bus.ihit | bus.dhit;
            if (bus.ihit) begin
                n_ihit++;
                if (cur_src != 1 || iq.size() == 0)
                    chk("ihit_expected", 1, 0);
                else begin
                    chk("iload", bus.iload, iq[0].exp);
                    void'(iq.pop_front());
                end
            end
            if (bus.dhit) begin
                n_dhit++;
                if (cur_src != 2 || dq.size() == 0)
                    chk("dhit_expected", 1, 0);
                else begin
                    chk("dload", bus.dload, dq[0].exp);
                    void'(dq.pop_front());
                end
            end
            if (!act) begin
                ireq = bus.iREN;
                dreq = bus.dREN | bus.dWEN;
                if (dreq && (streak < MAXS || !ireq)) begin
                    pred = 2;
                    streak = ireq ? streak + 1 : 0;
                end else if (ireq) begin
                    pred = 1;
                    streak = 0;
                end else begin
                    pred = 0;
                end
                have_pred = 1;
            end
        end
    end

    task automatic issue_i(input logic [31:0] a);
        itx_t t;
        t.addr = a;
        t.exp  = ifn(a);
        bus.iREN  = 1'b1;
        bus.iaddr = a;
        iq.push_back(t);
    endtask

    // kind: 0 read, 1 write, 2 read+write (acts as write)
    task automatic issue_d(input int kind, input logic [31:0] a,
                           input logic [31:0] d);
        dtx_t t;
        t.wr   = kind != 0;
        t.addr = a;
        t.data = d;
        t.exp  = t.wr ? 32'h0 : ref_mem[a[8:2]];
        if (t.wr) ref_mem[a[8:2]] = d;
        bus.dREN   = kind != 1;
        bus.dWEN   = kind != 0;
        bus.daddr  = a;
        bus.dstore = d;
        dq.push_back(t);
    endtask

    task automatic wait_hit(input bit d, output bit ok);
        ok = 0;
        for (int b = 0; b < 100; b++) begin
            @(negedge CLK);
            if (d ? bus.dhit : bus.ihit) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk(d ? "dhit_timeout" : "ihit_timeout", 0, 1);
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 0;
        for (int b = 0; b < 50; b++) begin
            @(negedge CLK);
            if (bus.ram_REN | bus.ram_WEN) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("strobe_timeout", 0, 1);
    endtask

    task automatic run_i(input int n, input int gap);
        bit ok;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap)) tick();
            issue_i(32'($urandom_range(0, 63)) * 4);
            wait_hit(1'b0, ok);
            tick();
            bus.iREN = 1'b0;
        end
    endtask

    task automatic run_d(input int n, input int gap);
        bit ok;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap)) tick();
            issue_d(int'($urandom_range(0, 2)),
                    32'h100 + 32'($urandom_range(0, 63)) * 4,
                    $urandom);
            wait_hit(1'b1, ok);
            tick();
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
        end
    endtask

    initial begin
        bit          ok;
        int          g;
        int          ihit_at;
        int          base;
        int          w;
        logic [31:0] old;

        for (int i = 0; i < 128; i++) begin
            ram[i] = (i < 64) ? ifn(32'(i * 4))
                              : (32'hC0DE_0000 | 32'(i));
            ref_mem[i] = ram[i];
        end
        bus.iREN = 0; bus.iaddr = '0;
        bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = '0; bus.dstore = '0;

        repeat (3) @(negedge CLK);
        chk("rst_ihit", 32'(bus.ihit), 0);
        chk("rst_dhit", 32'(bus.dhit), 0);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        chk("rst_ren", 32'(bus.ram_REN), 0);
        chk("rst_wen", 32'(bus.ram_WEN), 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_store", bus.ram_store, 0);
        chk("rst_error", 32'(bus.ram_error), 0);
        nRST = 1'b1;
        mon_en = 1;

        // lone fetch
        tick();
        lat_cfg = 2;
        issue_i(32'h40);
        wait_strobe(ok);
        chk("fetch_ren", 32'(bus.ram_REN), 1);
        chk("fetch_addr", bus.ram_addr, 32'h40);
        wait_hit(1'b0, ok);
        chk("fetch_iload", bus.iload, 32'h2002000A);
        tick();
        bus.iREN = 1'b0;
        @(negedge CLK);
        chk("fetch_pulse", 32'(bus.ihit), 0);
        chk("fetch_ren_off", 32'(bus.ram_REN), 0);

        // data beats fetch when both arrive together
        tick();
        issue_i(32'h44);
        issue_d(1, 32'h100, 32'hDEADBEEF);
        wait_strobe(ok);
        chk("prio_wen", 32'(bus.ram_WEN), 1);
        chk("prio_ren", 32'(bus.ram_REN), 0);
        chk("prio_addr", bus.ram_addr, 32'h100);
        chk("prio_store", bus.ram_store, 32'hDEADBEEF);
        wait_hit(1'b1, ok);
        tick();
        bus.dREN = 0; bus.dWEN = 0;
        g = 0;
        do begin
            @(negedge CLK);
            g++;
        end while (!bus.ram_REN && g < 10);
        chk("prio_igap", 32'(g), 2);
        wait_hit(1'b0, ok);
        tick();
        bus.iREN = 1'b0;

        // streak limit lets the held fetch in after MAXS data grants
        tick();
        lat_cfg = 1;
        base = n_dhit;
        ihit_at = -1;
        fork
            begin
                issue_i(32'h48);
                wait_hit(1'b0, ok);
                ihit_at = n_dhit - base;
                tick();
                bus.iREN = 1'b0;
            end
            run_d(6, 0);
        join
        chk("streak_dhits", 32'(ihit_at), MAXS);

        // flushed fetch, then a waiting data read
        tick();
        lat_cfg = 20;
        issue_i(32'h4C);
        wait_strobe(ok);
        @(negedge CLK);
        tick();
        bus.iREN = 1'b0;
        lat_cfg = 1;
        issue_d(0, 32'h104, 32'h0);
        @(negedge CLK);
        chk("abort_nohit", 32'(bus.ihit), 0);
        tick();
        void'(iq.pop_front());
        @(negedge CLK);
        chk("abort_idle", 32'(bus.ram_REN | bus.ram_WEN), 0);
        chk("abort_nohit2", 32'(bus.ihit), 0);
        @(negedge CLK);
        chk("abort_dgrant", 32'(bus.ram_REN), 1);
        chk("abort_daddr", bus.ram_addr, 32'h104);
        wait_hit(1'b1, ok);
        tick();
        bus.dREN = 0; bus.dWEN = 0;

        // asynchronous reset in the middle of a write
        tick();
        lat_cfg = 20;
        old = ref_mem[65];
        issue_d(1, 32'h104, 32'hA5A55A5A);
        wait_strobe(ok);
        chk("rstmid_wen_on", 32'(bus.ram_WEN), 1);
        #2;
        mon_en = 0;
        nRST = 1'b0;
        #1;
        chk("rstmid_wen", 32'(bus.ram_WEN), 0);
        chk("rstmid_dhit", 32'(bus.dhit), 0);
        chk("rstmid_addr", bus.ram_addr, 0);
        chk("rstmid_store", bus.ram_store, 0);
        dq.delete();
        ref_mem[65] = old;
        bus.dREN = 0; bus.dWEN = 0;
        @(negedge CLK);
        tick();
        nRST = 1'b1;
        mon_en = 1;

        // random traffic from both requesters
        lat_cfg = -1;
        tick();
        fork
            run_i(40, 2);
            run_d(40, 2);
        join
        repeat (3) @(negedge CLK);
        chk("iq_drained", 32'(iq.size()), 0);
        chk("dq_drained", 32'(dq.size()), 0);

        // watchdog
        mon_en = 0;
        tick();
        lat_cfg = 1000;
        issue_i(32'h20);
        w = 0;
        for (int b = 0; b < 40 && !bus.ram_error; b++) begin
            @(negedge CLK);
            if (bus.ram_REN) w++;
        end
        chk("tmo_cycles", 32'(w), TMO);
        chk("tmo_error", 32'(bus.ram_error), 1);
        chk("tmo_ren_off", 32'(bus.ram_REN), 0);
        tick();
        issue_d(0, 32'h108, 32'h0);
        repeat (6) begin
            @(negedge CLK);
            chk("err_nohit", 32'(bus.ihit | bus.dhit), 0);
            chk("err_nostrobe", 32'(bus.ram_REN | bus.ram_WEN), 0);
            chk("err_sticky", 32'(bus.ram_error), 1);
        end
        #1;
        nRST = 1'b0;
        #1;
        chk("err_cleared", 32'(bus.ram_error), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
